// File: rtl/spi_master_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// spi_master_cmd_sequencer_if
//   Bundles the handshake signals of spi_master_cmd_sequencer:
//     command stream  : i_cmd_valid / o_cmd_ready / i_cmd_data
//     response stream : o_rsp_valid / i_rsp_ready / o_rsp_data (show-ahead)
//     SPI_Master side : o_SPI_Send_Sync / o_SPI_Send_Data / i_SPI_Send_Over_ack /
//                       i_SPI_Receive_Sync / i_SPI_Receive_Data
//   Modports:
//     master : the sequencer itself
//     slave  : everything around it (system side plus SPI_Master)
// ---------------------------------------------------------------------------
interface spi_master_cmd_sequencer_if #(
   parameter int TRAN_WIDTH = 8
);
   logic                  i_cmd_valid;
   logic                  o_cmd_ready;
   logic [TRAN_WIDTH-1:0] i_cmd_data;

   logic                  o_rsp_valid;
   logic                  i_rsp_ready;
   logic [TRAN_WIDTH-1:0] o_rsp_data;

   logic                  o_SPI_Send_Sync;
   logic [31:0]           o_SPI_Send_Data;
   logic                  i_SPI_Send_Over_ack;
   logic                  i_SPI_Receive_Sync;
   logic [TRAN_WIDTH-1:0] i_SPI_Receive_Data;

   modport master (
      input  i_cmd_valid, i_cmd_data, i_rsp_ready,
             i_SPI_Send_Over_ack, i_SPI_Receive_Sync, i_SPI_Receive_Data,
      output o_cmd_ready, o_rsp_valid, o_rsp_data,
             o_SPI_Send_Sync, o_SPI_Send_Data
   );

   modport slave (
      output i_cmd_valid, i_cmd_data, i_rsp_ready,
             i_SPI_Send_Over_ack, i_SPI_Receive_Sync, i_SPI_Receive_Data,
      input  o_cmd_ready, o_rsp_valid, o_rsp_data,
             o_SPI_Send_Sync, o_SPI_Send_Data
   );
endinterface

// File: rtl/spi_master_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// spi_master_cmd_sequencer
//   Upstream feeder for one SPI_Master. Command words are queued in a command
//   FIFO and issued one at a time on the Send_Sync/Send_Over_ack handshake;
//   every received word is captured into a response FIFO. An idle gap is
//   enforced between transfers; lost responses and hung transfers are flagged.
//
// Ports
//   c_clk_100m      : system clock
//   i_rst_n         : asynchronous reset, active low
//   bus (master)    : command / response streams and SPI_Master handshake
//   i_clear_err     : synchronous clear of the sticky flags
//   o_busy          : FSM not in IDLE (registered)
//   o_rsp_overflow  : sticky, a received word was dropped (response FIFO full)
//   o_timeout       : sticky, ack not seen within TIMEOUT_CYCLES
//
// Build option
//   SPI_SEQ_TIMEOUT_EN : when defined, WAIT_ACK is bounded by TIMEOUT_CYCLES;
//                        when undefined, WAIT_ACK waits forever and o_timeout=0.
// ---------------------------------------------------------------------------
module spi_master_cmd_sequencer #(
   parameter int TRAN_WIDTH     = 8,
   parameter int CMD_DEPTH      = 8,
   parameter int RSP_DEPTH      = 8,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                        c_clk_100m,
   input  logic                        i_rst_n,
   spi_master_cmd_sequencer_if.master  bus,
   input  logic                        i_clear_err,
   output logic                        o_busy,
   output logic                        o_rsp_overflow,
   output logic                        o_timeout
);

   localparam int CMD_AW = $clog2(CMD_DEPTH);
   localparam int CMD_CW = CMD_AW + 1;
   localparam int RSP_AW = $clog2(RSP_DEPTH);
   localparam int RSP_CW = RSP_AW + 1;
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   localparam logic [CMD_CW-1:0] CMD_FULL = CMD_CW'(CMD_DEPTH);
   localparam logic [RSP_CW-1:0] RSP_FULL = RSP_CW'(RSP_DEPTH);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACK,
      GAP
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              state_q,      state_d;
   logic                sync_q,       sync_d;
   logic [31:0]         send_data_q,  send_data_d;
   logic                busy_q,       busy_d;
   logic [GAP_W-1:0]    gap_cnt_q,    gap_cnt_d;
   logic                overflow_q,   overflow_d;

   logic [CMD_AW-1:0]   cmd_wr_ptr_q, cmd_wr_ptr_d;
   logic [CMD_AW-1:0]   cmd_rd_ptr_q, cmd_rd_ptr_d;
   logic [CMD_CW-1:0]   cmd_cnt_q,    cmd_cnt_d;
   logic [RSP_AW-1:0]   rsp_wr_ptr_q, rsp_wr_ptr_d;
   logic [RSP_AW-1:0]   rsp_rd_ptr_q, rsp_rd_ptr_d;
   logic [RSP_CW-1:0]   rsp_cnt_q,    rsp_cnt_d;

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0]    tmo_cnt_q,    tmo_cnt_d;
   logic                timeout_q,    timeout_d;
   logic                timeout_set;
`endif

   logic [TRAN_WIDTH-1:0] cmd_mem [CMD_DEPTH];
   logic [TRAN_WIDTH-1:0] rsp_mem [RSP_DEPTH];

   logic cmd_push, cmd_pop, cmd_full, cmd_empty;
   logic rsp_push, rsp_pop, rsp_full, rsp_empty;
   logic start_ok, overflow_set;

   // ------------------------------------------------------------------------
   // FIFO status and handshakes
   // ------------------------------------------------------------------------
   assign cmd_full  = (cmd_cnt_q == CMD_FULL);
   assign cmd_empty = (cmd_cnt_q == '0);
   assign rsp_full  = (rsp_cnt_q == RSP_FULL);
   assign rsp_empty = (rsp_cnt_q == '0);

   assign cmd_push  = bus.i_cmd_valid & ~cmd_full;
   assign rsp_pop   = ~rsp_empty & bus.i_rsp_ready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign rsp_push     = bus.i_SPI_Receive_Sync & (~rsp_full | rsp_pop);
   assign overflow_set = bus.i_SPI_Receive_Sync & rsp_full & ~rsp_pop;

   // A transfer is only started when its response is guaranteed a slot.
   assign start_ok  = ~cmd_empty & ~rsp_full;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every *_d gets its hold value first, so no path through the
      // case statement can leave a signal unassigned and infer a latch.
      state_d     = state_q;
      sync_d      = sync_q;
      send_data_d = send_data_q;
      gap_cnt_d   = gap_cnt_q;
      cmd_pop     = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      timeout_set = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d     = SEND;
               cmd_pop     = 1'b1;
               send_data_d = 32'(cmd_mem[cmd_rd_ptr_q]);
            end
         end

         SEND: begin
            // Sync is registered, so it becomes visible as WAIT_ACK starts.
            state_d   = WAIT_ACK;
            sync_d    = 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end

         WAIT_ACK: begin
            if (bus.i_SPI_Send_Over_ack) begin
               state_d   = GAP;
               sync_d    = 1'b0;
               gap_cnt_d = '0;
            end
`ifdef SPI_SEQ_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               // Command is consumed; no retry.
               state_d     = GAP;
               sync_d      = 1'b0;
               gap_cnt_d   = '0;
               timeout_set = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end

         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               // The IDLE decision is folded into the last gap clock so that
               // back-to-back transfers see Sync low for GAP_CYCLES+1 clocks
               // (GAP_CYCLES in GAP plus the SEND clock).
               if (start_ok) begin
                  state_d     = SEND;
                  cmd_pop     = 1'b1;
                  send_data_d = 32'(cmd_mem[cmd_rd_ptr_q]);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);

      cmd_wr_ptr_d = cmd_wr_ptr_q + CMD_AW'(cmd_push);
      cmd_rd_ptr_d = cmd_rd_ptr_q + CMD_AW'(cmd_pop);
      cmd_cnt_d    = cmd_cnt_q + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);

      rsp_wr_ptr_d = rsp_wr_ptr_q + RSP_AW'(rsp_push);
      rsp_rd_ptr_d = rsp_rd_ptr_q + RSP_AW'(rsp_pop);
      rsp_cnt_d    = rsp_cnt_q + RSP_CW'(rsp_push) - RSP_CW'(rsp_pop);

      // Sticky flags: a set event in the clearing cycle wins.
      overflow_d = (overflow_q & ~i_clear_err) | overflow_set;
`ifdef SPI_SEQ_TIMEOUT_EN
      timeout_d  = (timeout_q & ~i_clear_err) | timeout_set;
`endif
   end

   // ------------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values no matter how the blocks are ordered.
   always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         sync_q       <= 1'b0;
         send_data_q  <= '0;
         busy_q       <= 1'b0;
         gap_cnt_q    <= '0;
         overflow_q   <= 1'b0;
         cmd_wr_ptr_q <= '0;
         cmd_rd_ptr_q <= '0;
         cmd_cnt_q    <= '0;
         rsp_wr_ptr_q <= '0;
         rsp_rd_ptr_q <= '0;
         rsp_cnt_q    <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         send_data_q  <= send_data_d;
         busy_q       <= busy_d;
         gap_cnt_q    <= gap_cnt_d;
         overflow_q   <= overflow_d;
         cmd_wr_ptr_q <= cmd_wr_ptr_d;
         cmd_rd_ptr_q <= cmd_rd_ptr_d;
         cmd_cnt_q    <= cmd_cnt_d;
         rsp_wr_ptr_q <= rsp_wr_ptr_d;
         rsp_rd_ptr_q <= rsp_rd_ptr_d;
         rsp_cnt_q    <= rsp_cnt_d;
`ifdef SPI_SEQ_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage
   // ------------------------------------------------------------------------
   // NOTE: the storage arrays have no reset; the reset pointers and counts
   // already mark every entry invalid, and resettable arrays cannot map to RAM.
   always_ff @(posedge c_clk_100m) begin
      if (cmd_push) cmd_mem[cmd_wr_ptr_q] <= bus.i_cmd_data;
      if (rsp_push) rsp_mem[rsp_wr_ptr_q] <= bus.i_SPI_Receive_Data;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.o_cmd_ready     = ~cmd_full;
   assign bus.o_rsp_valid     = ~rsp_empty;
   assign bus.o_rsp_data      = rsp_mem[rsp_rd_ptr_q];
   assign bus.o_SPI_Send_Sync = sync_q;
   assign bus.o_SPI_Send_Data = send_data_q;
   assign o_busy              = busy_q;
   assign o_rsp_overflow      = overflow_q;

`ifdef SPI_SEQ_TIMEOUT_EN
   assign o_timeout = timeout_q;
`else
   // Timeout hardware is compiled out; the parameter is still consumed so
   // both builds keep an identical parameter list.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign o_timeout          = 1'b0;
`endif

endmodule
